decoder_scan_n: RTL

//   Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with enable and two modes.
//   - Direct: decodes input address a.
//   - Scan: internal sequencer walks indices 0..last, holding each for dwell+1 cycles.

---
 rtl/decoder_pkg.sv | 14 +
 rtl/decoder_dwell_cnt.sv | 34 +++
 rtl/decoder_scan_n.sv | 108 ++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared mode constants and FSM state encoding for the one-hot scan decoder.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        BLANK  = 2'd3
    } dec_state_t;

endpackage

// File: rtl/decoder_dwell_cnt.sv
// Per-slot dwell counter: counts up from 0 and flags when it reaches the captured terminal value.
module decoder_dwell_cnt #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] terminal,
    output logic               tc_c
);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] term;

    // clear beats load beats count; load restarts the slot with a fresh length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            term <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt  <= '0;
            term <= terminal;
        end else if (en) begin
            cnt <= cnt + DWELL_W'(1);
        end
    end

    assign tc_c = (cnt == term);

endmodule

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct and scan modes.
// Optional anti-ghosting blank cycle between scan slots: define DECODER_SCAN_BLANK_EN.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       a,
    input  logic [DWELL_W-1:0]     dwell,
    input  logic [SEL_W-1:0]       last,
    output logic [(1<<SEL_W)-1:0]  y,
    output logic [SEL_W-1:0]       idx,
    output logic                   wrap
);

    localparam int unsigned OUT_W = 1 << SEL_W;

    dec_state_t       state;
    logic             tc_c;
    logic             scan_run_c;
    logic             enter_scan_c;
    logic             advance_c;
    logic             cnt_clear_c;
    logic             cnt_load_c;
    logic             cnt_en_c;
    logic [SEL_W-1:0] idx_nxt_c;

    // Counter control; a dropped enable or a switch to direct mode always zeroes the count
    always_comb begin
        scan_run_c   = en && (mode == MODE_SCAN);
        enter_scan_c = scan_run_c && ((state == IDLE) || (state == DIRECT));
        advance_c    = scan_run_c && (state == SCAN) && tc_c;
        cnt_clear_c  = !scan_run_c;
        cnt_load_c   = enter_scan_c || advance_c;
        cnt_en_c     = scan_run_c && (state == SCAN);
        idx_nxt_c    = (idx >= last) ? '0 : idx + SEL_W'(1);
    end

    decoder_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear_c),
        .load     (cnt_load_c),
        .en       (cnt_en_c),
        .terminal (dwell),
        .tc_c     (tc_c)
    );

    // FSM with registered strobe, index and wrap pulse; wrap defaults low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            y     <= '0;
            idx   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                state <= IDLE;
                y     <= '0;
                idx   <= '0;
            end else if (mode == MODE_DIRECT) begin
                state <= DIRECT;
                y     <= OUT_W'(1) << a;
                idx   <= a;
            end else begin
                case (state)
                    IDLE, DIRECT: begin
                        state <= SCAN;
                        y     <= OUT_W'(1);
                        idx   <= '0;
                    end
                    SCAN: begin
                        if (advance_c) begin
                            idx  <= idx_nxt_c;
                            wrap <= (idx >= last);
`ifdef DECODER_SCAN_BLANK_EN
                            state <= BLANK;
                            y     <= '0;
`else
                            y     <= OUT_W'(1) << idx_nxt_c;
`endif
                        end
                    end
`ifdef DECODER_SCAN_BLANK_EN
                    BLANK: begin
                        state <= SCAN;
                        y     <= OUT_W'(1) << idx;
                    end
`endif
                    default: begin
                        state <= IDLE;
                        y     <= '0;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
